hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 87 ++++++++
 tb/tb_hazard_scoreboard.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight destination writes and resolves source operands
// to a forwarding slot, or stalls issue until the producing result is forwardable.
module hazard_scoreboard #(
  parameter int NUM_REGS       = 32,
  parameter int NUM_READ_PORTS = 2,
  parameter int DEPTH          = 3,
  parameter int FLUSH_SLOTS    = 1,
  parameter int CNT_W          = 8,
  localparam int AW = $clog2(NUM_REGS),
  localparam int SW = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         advance,
  input  logic                         flush,
  input  logic                         issue_valid,
  output logic                         issue_ready,
  input  logic                         issue_we,
  input  logic [AW-1:0]                issue_rd,
  input  logic [SW-1:0]                issue_ready_at,
  input  logic [NUM_READ_PORTS-1:0]    src_use,
  input  logic [NUM_READ_PORTS*AW-1:0] src_addr,
  output logic [NUM_READ_PORTS*SW-1:0] fwd_sel,
  output logic                         stall,
  output logic [NUM_REGS-1:0]          pending,
  output logic [CNT_W-1:0]             stall_cycles
);
  localparam logic [SW-1:0] DS = SW'(DEPTH);
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [AW-1:0] rd_q [DEPTH];
  logic [AW-1:0] rd_d [DEPTH];
  logic [SW-1:0] rat_q [DEPTH];
  logic [SW-1:0] rat_d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_READ_PORTS-1:0] hz;
  logic [SW-1:0] rat_in;
  assign rat_in = (issue_ready_at == '0 || issue_ready_at > DS) ? DS : issue_ready_at;
  assign stall = issue_valid && |hz;
  assign issue_ready = advance && !stall && !flush;
  assign stall_cycles = cnt_q;
  // Scan oldest to youngest so the youngest matching slot decides.
  always_comb begin
    fwd_sel = {NUM_READ_PORTS{DS}};
    hz = '0;
    for (int p = 0; p < NUM_READ_PORTS; p++)
      for (int k = DEPTH - 1; k >= 0; k--)
        if (src_use[p] && src_addr[p*AW +: AW] != '0 && valid_q[k] && rd_q[k] == src_addr[p*AW +: AW]) begin
          fwd_sel[p*SW +: SW] = SW'(k) >= rat_q[k] ? SW'(k) : DS;
          hz[p] = SW'(k) < rat_q[k];
        end
  end
  always_comb begin
    pending = '0;
    for (int k = 0; k < DEPTH; k++)
      if (valid_q[k]) pending[rd_q[k]] = 1'b1;
  end
  always_comb begin
    valid_d = valid_q;
    rd_d = rd_q;
    rat_d = rat_q;
    if (advance) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        valid_d[i] = valid_q[i-1];
        rd_d[i] = rd_q[i-1];
        rat_d[i] = rat_q[i-1];
      end
      valid_d[0] = issue_valid && issue_ready && issue_we && issue_rd != '0;
      rd_d[0] = issue_rd;
      rat_d[0] = rat_in;
    end
    if (flush)
      for (int i = 0; i < FLUSH_SLOTS; i++) valid_d[i] = 1'b0;
    cnt_d = stall ? (&cnt_q ? cnt_q : cnt_q + 1'b1) : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_q <= '0;
      rd_q <= '{default: '0};
      rat_q <= '{default: '0};
      cnt_q <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q <= rd_d;
      rat_q <= rat_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vector table, hand sequences for saturation and
// asynchronous reset, then random traffic against a queue-based slot model.
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst_n, advance, flush, issue_valid, issue_we, issue_ready, stall;
  logic [4:0] issue_rd;
  logic [1:0] issue_ready_at, src_use;
  logic [9:0] src_addr;
  logic [3:0] fwd_sel;
  logic [31:0] pending;
  logic [7:0] stall_cycles;
  int checks = 0;
  int failures = 0;

  hazard_scoreboard #(.NUM_REGS(32), .NUM_READ_PORTS(2), .DEPTH(3), .FLUSH_SLOTS(1), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .advance(advance), .flush(flush), .issue_valid(issue_valid),
    .issue_ready(issue_ready), .issue_we(issue_we), .issue_rd(issue_rd),
    .issue_ready_at(issue_ready_at), .src_use(src_use), .src_addr(src_addr),
    .fwd_sel(fwd_sel), .stall(stall), .pending(pending), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic adv, fl, iv, we;
    logic [4:0] rd;
    logic [1:0] rat, u;
    logic [4:0] a0, a1;
    logic es, er;
    logic [1:0] f0, f1;
    logic [31:0] pd;
    logic [7:0] c;
  } vec_t;
  vec_t tbl[$];

  typedef struct {bit v; bit [4:0] rd; int rat;} ent_t;
  ent_t mq[$];
  int mcnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] b(input int n);
    return 32'h1 << n;
  endfunction

  function automatic vec_t mk(input logic adv, fl, iv, we, input logic [4:0] rd, input logic [1:0] rat, u,
                              input logic [4:0] a0, a1, input logic es, er, input logic [1:0] f0, f1,
                              input logic [31:0] pd, input logic [7:0] c);
    vec_t v;
    v.adv = adv; v.fl = fl; v.iv = iv; v.we = we; v.rd = rd; v.rat = rat; v.u = u;
    v.a0 = a0; v.a1 = a1; v.es = es; v.er = er; v.f0 = f0; v.f1 = f1; v.pd = pd; v.c = c;
    return v;
  endfunction

  task automatic drive(input logic adv, fl, iv, we, input logic [4:0] rd, input logic [1:0] rat, u,
                       input logic [4:0] a0, a1);
    advance = adv; flush = fl; issue_valid = iv; issue_we = we; issue_rd = rd;
    issue_ready_at = rat; src_use = u; src_addr = {a1, a0};
  endtask

  task automatic m_reset();
    mq.delete();
    repeat (3) mq.push_back('{1'b0, 5'd0, 3});
    mcnt = 0;
  endtask

  function automatic logic [31:0] m_pend();
    logic [31:0] r = '0;
    foreach (mq[k]) if (mq[k].v) r[mq[k].rd] = 1'b1;
    return r;
  endfunction

  task automatic m_eval(output bit es, output bit er, output int f0, output int f1);
    bit hz = 0;
    int ff[2];
    for (int p = 0; p < 2; p++) begin
      logic [4:0] a = p == 0 ? src_addr[4:0] : src_addr[9:5];
      ff[p] = 3;
      if (src_use[p] && a != 0)
        for (int k = 0; k < 3; k++)
          if (mq[k].v && mq[k].rd == a) begin
            if (k >= mq[k].rat) ff[p] = k; else hz = 1;
            break;
          end
    end
    es = issue_valid && hz;
    er = advance && !es && !flush;
    f0 = ff[0];
    f1 = ff[1];
  endtask

  task automatic m_next(input bit es, input bit er);
    if (advance) begin
      ent_t e;
      e.v = issue_valid && er && issue_we && issue_rd != 0;
      e.rd = issue_rd;
      e.rat = (issue_ready_at == 0 || issue_ready_at > 3) ? 3 : int'(issue_ready_at);
      mq.push_front(e);
      void'(mq.pop_back());
    end
    if (flush) mq[0].v = 0;
    mcnt = es ? (mcnt == 255 ? 255 : mcnt + 1) : 0;
  endtask

  initial begin
    bit es, er;
    int f0, f1;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 2'b11, 5, 9);
    #12;
    chk("reset_pending", pending, 0);
    chk("reset_cnt", stall_cycles, 0);
    chk("reset_fwd", fwd_sel, 4'hf);
    chk("reset_stall", stall, 0);
    #8 rst_n = 1'b1;

    tbl.push_back(mk(1,0,1,1, 5,1,0, 0,0, 0,1,3,3, b(5),0));
    tbl.push_back(mk(1,0,1,1, 9,1,1, 5,0, 1,0,3,3, b(5),1));
    tbl.push_back(mk(1,0,1,1, 9,1,1, 5,0, 0,1,1,3, b(5)|b(9),0));
    tbl.push_back(mk(1,0,0,0, 0,0,0, 0,0, 0,1,3,3, b(9),0));
    tbl.push_back(mk(1,0,0,0, 0,0,0, 0,0, 0,1,3,3, b(9),0));
    tbl.push_back(mk(1,0,0,0, 0,0,0, 0,0, 0,1,3,3, 0,0));
    tbl.push_back(mk(1,0,1,1, 7,2,0, 0,0, 0,1,3,3, b(7),0));
    tbl.push_back(mk(1,0,1,1, 8,1,1, 7,0, 1,0,3,3, b(7),1));
    tbl.push_back(mk(1,0,1,1, 8,1,1, 7,0, 1,0,3,3, b(7),2));
    tbl.push_back(mk(1,0,1,1, 8,1,1, 7,0, 0,1,2,3, b(8),0));
    tbl.push_back(mk(1,0,0,0, 0,0,0, 0,0, 0,1,3,3, b(8),0));
    tbl.push_back(mk(1,0,0,0, 0,0,2, 0,8, 0,1,3,1, b(8),0));
    tbl.push_back(mk(1,0,0,0, 0,0,2, 0,8, 0,1,3,2, 0,0));
    tbl.push_back(mk(1,0,1,1, 3,1,0, 0,0, 0,1,3,3, b(3),0));
    tbl.push_back(mk(1,0,1,1, 3,1,0, 0,0, 0,1,3,3, b(3),0));
    tbl.push_back(mk(1,0,0,0, 0,0,0, 0,0, 0,1,3,3, b(3),0));
    tbl.push_back(mk(1,0,1,1,10,1,1, 3,0, 0,1,1,3, b(3)|b(10),0));
    tbl.push_back(mk(1,0,0,0, 0,0,0, 0,0, 0,1,3,3, b(10),0));
    tbl.push_back(mk(1,0,0,0, 0,0,0, 0,0, 0,1,3,3, b(10),0));
    tbl.push_back(mk(1,0,0,0, 0,0,0, 0,0, 0,1,3,3, 0,0));
    tbl.push_back(mk(1,0,1,1, 0,1,1, 0,0, 0,1,3,3, 0,0));
    tbl.push_back(mk(1,0,1,0, 6,1,0, 0,0, 0,1,3,3, 0,0));
    tbl.push_back(mk(1,0,1,0, 0,1,1, 6,0, 0,1,3,3, 0,0));
    tbl.push_back(mk(1,1,1,1,12,1,0, 0,0, 0,0,3,3, 0,0));
    tbl.push_back(mk(1,0,1,1,13,2,0, 0,0, 0,1,3,3, b(13),0));
    tbl.push_back(mk(0,1,0,0, 0,0,0, 0,0, 0,0,3,3, 0,0));
    tbl.push_back(mk(1,0,1,1,14,1,0, 0,0, 0,1,3,3, b(14),0));
    tbl.push_back(mk(1,1,1,1,15,1,0, 0,0, 0,0,3,3, b(14),0));
    tbl.push_back(mk(0,0,1,1,16,1,1,14,0, 0,0,1,3, b(14),0));
    tbl.push_back(mk(1,0,0,0, 0,0,0, 0,0, 0,1,3,3, b(14),0));
    tbl.push_back(mk(1,0,0,0, 0,0,0, 0,0, 0,1,3,3, 0,0));
    tbl.push_back(mk(1,0,1,1,20,0,0, 0,0, 0,1,3,3, b(20),0));
    tbl.push_back(mk(1,0,1,0, 0,1,1,20,0, 1,0,3,3, b(20),1));
    tbl.push_back(mk(1,0,1,0, 0,1,1,20,0, 1,0,3,3, b(20),2));
    tbl.push_back(mk(1,0,1,0, 0,1,1,20,0, 1,0,3,3, 0,3));
    tbl.push_back(mk(1,0,1,0, 0,1,1,20,0, 0,1,3,3, 0,0));

    foreach (tbl[i]) begin
      drive(tbl[i].adv, tbl[i].fl, tbl[i].iv, tbl[i].we, tbl[i].rd, tbl[i].rat, tbl[i].u, tbl[i].a0, tbl[i].a1);
      #1;
      chk($sformatf("v%0d_stall", i), stall, tbl[i].es);
      chk($sformatf("v%0d_ready", i), issue_ready, tbl[i].er);
      chk($sformatf("v%0d_fwd0", i), fwd_sel[1:0], tbl[i].f0);
      chk($sformatf("v%0d_fwd1", i), fwd_sel[3:2], tbl[i].f1);
      @(posedge clk); #1;
      chk($sformatf("v%0d_pending", i), pending, tbl[i].pd);
      chk($sformatf("v%0d_cnt", i), stall_cycles, tbl[i].c);
    end

    drive(1, 0, 1, 1, 4, 1, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 1, 0, 0, 1, 1, 4, 0);
    repeat (260) @(posedge clk);
    #1;
    chk("sat_cnt", stall_cycles, 255);
    chk("sat_stall", stall, 1);
    drive(0, 0, 0, 0, 0, 0, 1, 4, 0);
    @(posedge clk); #1;
    chk("sat_clear", stall_cycles, 0);
    chk("sat_hold_pending", pending, b(4));

    drive(1, 0, 1, 1, 11, 1, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 1, 11, 0);
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d_pending", n), pending, b(4) | b(11));
    end
    chk("hold_fwd", fwd_sel, 4'hf);
    drive(0, 0, 1, 0, 0, 0, 1, 4, 0);
    #1;
    chk("hold_fwd_slot1", fwd_sel[1:0], 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_pending", pending, 0);
    chk("async_fwd", fwd_sel, 4'hf);
    chk("async_stall", stall, 0);
    #3 rst_n = 1'b1;
    drive(1, 0, 1, 1, 21, 1, 0, 0, 0);
    #1;
    chk("first_ready", issue_ready, 1);
    @(posedge clk); #1;
    chk("first_pending", pending, b(21));

    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    m_reset();
    chk("rand_start_pending", pending, 0);
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7,
            $urandom_range(0, 5) != 0, 5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      #1;
      m_eval(es, er, f0, f1);
      chk("rnd_stall", stall, es);
      chk("rnd_ready", issue_ready, er);
      chk("rnd_fwd0", fwd_sel[1:0], f0);
      chk("rnd_fwd1", fwd_sel[3:2], f1);
      m_next(es, er);
      @(posedge clk); #1;
      chk("rnd_pending", pending, m_pend());
      chk("rnd_cnt", stall_cycles, mcnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
